// File: rtl/dm.sv
// dm: word-addressed data memory for the single-cycle MIPS datapath.
// Little-endian, sub-word stores by read-modify-write, sign/zero-extending
// sub-word loads, alignment and range checking. Synchronous write,
// asynchronous read, whole array cleared by synchronous reset.
// Optional macro DM_WRITE_LOG_EN prints one line per committed store.
module dm #(
    parameter int WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        mem_write,
    input  logic [1:0]  st_type,
    input  logic [2:0]  ld_type,
    output logic [31:0] rd,
    output logic        misalign
);

    localparam int          AW    = $clog2(WORDS);
    localparam logic [31:0] LIMIT = 32'(4 * WORDS);

    logic [31:0]   mem [WORDS];
    logic [AW-1:0] idx;
    logic          in_range;
    logic [31:0]   word;
    logic          ld_mis;
    logic          st_mis;
    logic [15:0]   half;
    logic [7:0]    byte_sel;
    logic [31:0]   merged;
    logic          we;

    assign idx      = addr[AW+1:2];
    assign in_range = (addr < LIMIT);
    // Out-of-range indices never reach the array
    assign word     = in_range ? mem[idx] : 32'h0;
    assign half     = addr[1] ? word[31:16] : word[15:0];

    // Byte lane select for lb/lbu
    always_comb begin
        byte_sel = word[7:0];
        case (addr[1:0])
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
    end

    // Alignment rules for the load and store flavours
    always_comb begin
        ld_mis = 1'b0;
        st_mis = 1'b0;
        case (ld_type)
            3'b000:         ld_mis = (addr[1:0] != 2'b00);
            3'b001, 3'b010: ld_mis = addr[0];
            default:        ld_mis = 1'b0;
        endcase
        case (st_type)
            2'b00:   st_mis = (addr[1:0] != 2'b00);
            2'b01:   st_mis = addr[0];
            default: st_mis = 1'b0;
        endcase
    end

    assign misalign = !in_range || (mem_write ? st_mis : ld_mis);

    // Load extraction and extension; bad loads read as zero
    always_comb begin
        rd = 32'h0;
        if (in_range && !ld_mis) begin
            case (ld_type)
                3'b000:  rd = word;
                3'b001:  rd = {{16{half[15]}}, half};
                3'b010:  rd = {16'h0, half};
                3'b011:  rd = {{24{byte_sel[7]}}, byte_sel};
                3'b100:  rd = {24'h0, byte_sel};
                default: rd = 32'h0;
            endcase
        end
    end

    // Merge store data into the old word at the addressed lane(s)
    always_comb begin
        merged = word;
        case (st_type)
            2'b00: merged = wd;
            2'b01: begin
                if (addr[1]) merged[31:16] = wd[15:0];
                else         merged[15:0]  = wd[15:0];
            end
            2'b10: begin
                case (addr[1:0])
                    2'd0: merged[7:0]   = wd[7:0];
                    2'd1: merged[15:8]  = wd[7:0];
                    2'd2: merged[23:16] = wd[7:0];
                    2'd3: merged[31:24] = wd[7:0];
                    default: merged = word;
                endcase
            end
            default: merged = word;
        endcase
    end

    // Reserved store type never writes
    assign we = mem_write && (st_type != 2'b11) && !misalign;

    // Array update: reset clears every word in one edge and beats any store
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
        end else if (we) begin
            mem[idx] <= merged;
        end
    end

`ifdef DM_WRITE_LOG_EN
    // Store trace: logs the full merged word, not the raw store data
    always_ff @(posedge clk) begin
        if (!reset && we)
            $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm.sv
// Scoreboard bench for dm: stimulus pushes expected rd/misalign per cycle,
// a negedge monitor pops and compares.
module tb_dm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        mem_write;
    logic [1:0]  st_type;
    logic [2:0]  ld_type;
    logic [31:0] rd;
    logic        misalign;

    logic        chk = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        logic        chk_rd;
        logic [31:0] rd;
        logic        mis;
        string       name;
    } exp_t;

    exp_t q[$];

    dm #(.WORDS(3072)) dut (
        .clk(clk), .reset(reset), .pc(pc), .addr(addr), .wd(wd),
        .mem_write(mem_write), .st_type(st_type), .ld_type(ld_type),
        .rd(rd), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus; optionally queue the expected response
    task automatic apply(input logic rst, input logic mw, input logic [1:0] st,
                         input logic [2:0] ld, input logic [31:0] a,
                         input logic [31:0] d, input logic do_chk,
                         input logic chk_rd, input logic [31:0] erd,
                         input logic emis, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; mem_write = mw; st_type = st; ld_type = ld;
        addr = a; wd = d; pc = pc + 32'd4;
        if (do_chk) begin
            e.chk_rd = chk_rd; e.rd = erd; e.mis = emis; e.name = name;
            q.push_back(e);
        end
        chk = do_chk;
    endtask

    task automatic ld(input logic [2:0] t, input logic [31:0] a,
                      input logic [31:0] erd, input logic emis, input string name);
        apply(1'b0, 1'b0, 2'b00, t, a, 32'h0, 1'b1, 1'b1, erd, emis, name);
    endtask

    task automatic st(input logic [1:0] t, input logic [31:0] a,
                      input logic [31:0] d, input logic emis, input string name);
        apply(1'b0, 1'b1, t, 3'b011, a, d, 1'b1, 1'b0, 32'h0, emis, name);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (chk) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: no expected entry queued");
            end else begin
                e = q.pop_front();
                n_checks++;
                if (misalign !== e.mis) begin
                    n_fail++;
                    $display("FAIL %s misalign: got %0b expected %0b", e.name, misalign, e.mis);
                end
                if (e.chk_rd) begin
                    n_checks++;
                    if (rd !== e.rd) begin
                        n_fail++;
                        $display("FAIL %s rd: got %h expected %h", e.name, rd, e.rd);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; mem_write = 1'b0; st_type = 2'b00; ld_type = 3'b000;
        addr = 32'h0; wd = 32'h0; pc = 32'h0000_3000;
        apply(1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, "rst");
        apply(1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, "rst");

        ld(3'b000, 32'h0000_0000, 32'h0000_0000, 1'b0, "rst_lw_0");
        ld(3'b000, 32'h0000_2FFC, 32'h0000_0000, 1'b0, "rst_lw_top");

        // sw with same-cycle load of the old contents
        apply(1'b0, 1'b1, 2'b00, 3'b000, 32'h10, 32'h1234_5678, 1'b1, 1'b1,
              32'h0, 1'b0, "sw_10_oldread");
        ld(3'b000, 32'h10, 32'h1234_5678, 1'b0, "lw_10");
        ld(3'b011, 32'h13, 32'h0000_0012, 1'b0, "lb_13");
        ld(3'b100, 32'h10, 32'h0000_0078, 1'b0, "lbu_10");
        ld(3'b001, 32'h12, 32'h0000_1234, 1'b0, "lh_12");

        st(2'b10, 32'h11, 32'hFFFF_FF80, 1'b0, "sb_11");
        ld(3'b000, 32'h10, 32'h1234_8078, 1'b0, "lw_10_sb");
        ld(3'b011, 32'h11, 32'hFFFF_FF80, 1'b0, "lb_11");
        ld(3'b100, 32'h11, 32'h0000_0080, 1'b0, "lbu_11");

        st(2'b01, 32'h22, 32'h0000_BEEF, 1'b0, "sh_22");
        ld(3'b000, 32'h20, 32'hBEEF_0000, 1'b0, "lw_20");
        ld(3'b001, 32'h22, 32'hFFFF_BEEF, 1'b0, "lh_22");
        ld(3'b010, 32'h22, 32'h0000_BEEF, 1'b0, "lhu_22");

        // Suppressed stores
        st(2'b00, 32'h15, 32'hDEAD_BEEF, 1'b1, "sw_15_mis");
        st(2'b01, 32'h13, 32'hDEAD_BEEF, 1'b1, "sh_13_mis");
        ld(3'b000, 32'h10, 32'h1234_8078, 1'b0, "lw_10_unchanged");
        st(2'b00, 32'h3000, 32'hDEAD_BEEF, 1'b1, "sw_3000_oor");
        ld(3'b000, 32'h3000, 32'h0, 1'b1, "lw_3000_oor");
        st(2'b00, 32'h4000, 32'hCAFE_F00D, 1'b1, "sw_4000_oor");
        ld(3'b000, 32'h0, 32'h0, 1'b0, "lw_0_noalias");
        st(2'b11, 32'h30, 32'h7777_7777, 1'b0, "st_reserved");
        ld(3'b000, 32'h30, 32'h0, 1'b0, "lw_30_noreserved");

        // Load alignment boundaries
        ld(3'b001, 32'h21, 32'h0, 1'b1, "lh_21_mis");
        ld(3'b000, 32'h12, 32'h0, 1'b1, "lw_12_mis");
        ld(3'b100, 32'h13, 32'h0000_0012, 1'b0, "lbu_13");
        ld(3'b101, 32'h10, 32'h0, 1'b0, "ld_reserved");

        // Back-to-back sub-word stores into one word
        st(2'b10, 32'h50, 32'h0000_0011, 1'b0, "sb_50");
        st(2'b10, 32'h51, 32'h0000_0022, 1'b0, "sb_51");
        ld(3'b000, 32'h50, 32'h0000_2211, 1'b0, "lw_50_b2b");

        // Reset cycle still shows pre-reset contents, then clears
        apply(1'b1, 1'b0, 2'b00, 3'b000, 32'h50, 32'h0, 1'b1, 1'b1,
              32'h0000_2211, 1'b0, "rst_cycle_rd");
        ld(3'b000, 32'h50, 32'h0, 1'b0, "lw_50_cleared");
        st(2'b00, 32'h10, 32'h5A5A_5A5A, 1'b0, "sw_10_again");
        apply(1'b1, 1'b1, 2'b00, 3'b000, 32'h40, 32'hAAAA_AAAA, 1'b1, 1'b1,
              32'h0, 1'b0, "sw_40_with_rst");
        ld(3'b000, 32'h40, 32'h0, 1'b0, "lw_40_rst_wins");
        ld(3'b000, 32'h10, 32'h0, 1'b0, "lw_10_cleared");

        apply(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, "idle");
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm.md
# dm

Word-addressed data memory for the single-cycle MIPS datapath, directly downstream of the ALU: the ALU `result` is this block's byte address, and the `rt` value from the GRF is the store data. It performs sub-word stores (read-modify-write), sign- and zero-extending sub-word loads, and alignment checking. It holds 3072 words (12 KiB) in a synchronous-write, asynchronous-read array that is cleared by reset.

## Interface
- `WORDS`, 3072: array depth in 32-bit words; valid byte range is 0 to 4*WORDS-1.
- `clk` in 1: system clock; all state updates occur on the rising edge.
- `reset` in 1: synchronous, active-high; clears the whole array.
- `pc` in 32: PC of the current instruction; used only for the write log.
- `addr` in 32: byte address, taken from the ALU result.
- `wd` in 32: store data (GRF rt); the low byte or halfword is used for sb/sh.
- `mem_write` in 1: store enable for this cycle.
- `st_type` in 2: 00 sw, 01 sh, 10 sb, 11 reserved (never writes).
- `ld_type` in 3: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, others give `rd`=0.
- `rd` out 32: extended load data (combinational).
- `misalign` out 1: current access is misaligned or out of range (combinational).

## Operation
- Byte order is little-endian: byte k of word w is `mem[w][8k+7:8k]`. Word index is `addr[13:2]`; byte offset is `addr[1:0]`.
- Read path (combinational):
  - Fetch the word at the index.
  - lh/lhu select the halfword by `addr[1]`; lb/lbu select the byte by `addr[1:0]`.
  - lh/lb sign-extend; lhu/lbu zero-extend.
- Write path:
  - The merged word equals the old word with the target lane(s) replaced.
  - sw replaces all 4 bytes. sh replaces the halfword at `addr[1]` with `wd[15:0]`. sb replaces the byte at `addr[1:0]` with `wd[7:0]`.
- `misalign` is 1 when any of the following holds:
  - sw, or lw when `mem_write`=0, with `addr[1:0]`≠0.
  - sh, lh or lhu with `addr[0]`=1.
  - `addr` ≥ 4*WORDS.
- Misaligned or out-of-range stores are suppressed: the array is unchanged.
- Misaligned or out-of-range loads return `rd`=0.
- Which access is checked:
  - `mem_write`=1: alignment is checked against `st_type`.
  - `mem_write`=0: alignment is checked against `ld_type`.
- No internal FSM; the only state is the array.

## Timing
- Store: the merged word is written at the rising edge where `mem_write`=1, `reset`=0, `st_type`≠11 and `misalign`=0.
- A load in the same cycle as a store to the same word returns the old contents. The new value is visible from the next cycle.
- Reset:
  - At a rising edge with `reset`=1, every word becomes 0 in that single edge.
  - Reset overrides any concurrent store.
  - During the reset cycle, `rd` still reflects the pre-reset contents.
- Reset values: all array words 0. Therefore `rd`=0 in the first cycle after reset for any aligned in-range load.
- Back-to-back stores to the same word in consecutive cycles compose correctly: the second merge reads the first result.
- Outputs `rd` and `misalign` have zero cycles of latency from `addr`, `ld_type`, `st_type`, `mem_write`.

## Configuration
- `DM_WRITE_LOG_EN`:
  - Defined: on every committed store, the block emits `$display("@%h: *%h <= %h", pc, {addr[31:2],2'b00}, merged_word)` at that clock edge. The logged value is the full merged word, not `wd`. Suppressed or reset-overridden stores emit nothing.
  - Undefined: no log statements are compiled in. Functional behaviour is identical.

## Test plan
- Reset, then lw at 0x0 and at 0x2FFC -> `rd`=0x00000000, `misalign`=0.
- sw 0x12345678 at 0x10; next cycle lw 0x10 -> 0x12345678.
  - lb 0x13 -> 0x00000012. lbu 0x10 -> 0x00000078.
  - lh 0x12 -> 0x00001234.
- sb wd=0xFFFFFF80 at 0x11 over 0x12345678 -> word 0x12348078.
  - lb 0x11 -> 0xFFFFFF80. lbu 0x11 -> 0x00000080.
  - With `DM_WRITE_LOG_EN`, the log shows `*00000010 <= 12348078`.
- sh 0xBEEF at 0x22 over 0 -> word 0xBEEF0000. lh 0x22 -> 0xFFFFBEEF. lhu 0x22 -> 0x0000BEEF.
- sw at 0x15 and sh at 0x13 -> `misalign`=1, word unchanged.
  - sw at 0x3000 -> `misalign`=1, no write.
  - lw 0x3000 -> `rd`=0.
- sw 0xAAAAAAAA at 0x40 with `reset`=1 in the same cycle -> next cycle lw 0x40 = 0; no log line.
